// File: rtl/video_timing_lock_if.sv
// video_timing_lock_if
//   Groups the pixel-FIFO read port and the video output bus of the timing
//   generator.
//   master (timing generator): drives rd_en, hs, vs, de, vout_data, x, y;
//                              samples fifo_empty, fifo_q.
//   slave  (FIFO / encoder side): the mirror image.
//   Signals:
//     rd_en      FIFO read strobe
//     fifo_empty external FIFO empty flag
//     fifo_q     FIFO read data, valid one cycle after rd_en
//     hs, vs, de registered sync / data enable
//     vout_data  pixel aligned with de (0 when de is low)
//     x, y       column / row of the current de pixel
interface video_timing_lock_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_W      = 12
);
  logic                  rd_en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_q;
  logic                  hs;
  logic                  vs;
  logic                  de;
  logic [DATA_WIDTH-1:0] vout_data;
  logic [CNT_W-1:0]      x;
  logic [CNT_W-1:0]      y;

  modport master (
    output rd_en, hs, vs, de, vout_data, x, y,
    input  fifo_empty, fifo_q
  );

  modport slave (
    input  rd_en, hs, vs, de, vout_data, x, y,
    output fifo_empty, fifo_q
  );
endinterface

// File: rtl/video_timing_lock.sv
// video_timing_lock
//   Raster timing generator (hs/vs/de) with programmable porches and sync
//   polarities. Reads pixels from an external one-cycle-latency FIFO and can
//   phase-lock the raster to a camera frame-start edge after a programmable
//   delay (free-run, one-shot lock, or continuous resync).
//   Ports:
//     video_clk   pixel clock, the only clock
//     rst         synchronous active-high reset
//     frame_in    camera frame-start level (video_clk domain)
//     lock_en     1 = lock raster to frame_in, 0 = free-run
//     resync_en   1 = every frame_in rising edge in RUN re-locks
//     lock_delay  clocks from detected edge to raster start
//     vid         FIFO read port + video output bus (master modport)
//     frame_done  one-cycle pulse on the last clock of a frame
//     locked      high in RUN while lock_en = 1
//     underflow   sticky: FIFO read while empty
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   WAIT  | idle after reset, counters at 0, waiting for lock edge
//   DELAY | edge seen, counting lock_delay clocks, counters held at 0
//   RUN   | raster running, counters advance every clock
module video_timing_lock #(
  parameter int DATA_WIDTH = 16,
  parameter int H_ACTIVE   = 480,
  parameter int H_FP       = 2,
  parameter int H_SYNC     = 41,
  parameter int H_BP       = 2,
  parameter int V_ACTIVE   = 272,
  parameter int V_FP       = 2,
  parameter int V_SYNC     = 10,
  parameter int V_BP       = 2,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int CNT_W      = 12,
  parameter int DLY_W      = 20
) (
  input  logic               video_clk,
  input  logic               rst,
  input  logic               frame_in,
  input  logic               lock_en,
  input  logic               resync_en,
  input  logic [DLY_W-1:0]   lock_delay,
  video_timing_lock_if.master vid,
  output logic               frame_done,
  output logic               locked,
  output logic               underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_DELAY = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      h_cnt;
  logic [CNT_W-1:0]      v_cnt;
  logic [DLY_W-1:0]      dly;
  logic                  frame_in_d;
  logic                  frame_edge;
  logic                  de_i;
  logic                  hs_i;
  logic                  vs_i;
  logic                  rd_en_i;
  logic                  stay_run;
  logic                  hs_q;
  logic                  vs_q;
  logic                  de_q;
  logic [CNT_W-1:0]      x_q;
  logic [CNT_W-1:0]      y_q;
  logic [DATA_WIDTH-1:0] pix_d;

  assign frame_edge = frame_in & ~frame_in_d;

  assign de_i = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_i = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_i = (v_cnt >= VS_START) && (v_cnt < VS_END);

  always_comb begin
    state_nxt  = state;
    rd_en_i    = 1'b0;
    frame_done = 1'b0;
    locked     = 1'b0;
    stay_run   = 1'b0;
    case (state)
      S_WAIT: begin
        if (!lock_en) begin
          state_nxt = S_RUN;
        end else if (frame_edge) begin
          state_nxt = S_DELAY;
        end
      end
      S_DELAY: begin
        if (dly == lock_delay) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        rd_en_i    = de_i;
        frame_done = (h_cnt == H_LAST) && (v_cnt == V_LAST);
        locked     = lock_en;
        if (frame_edge && lock_en && resync_en) begin
          state_nxt = S_DELAY;
        end else begin
          stay_run = 1'b1;
        end
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  // Registered outputs are qualified with stay_run so that a resync edge
  // blanks the pixel read in that cycle instead of emitting a partial line.
  always_ff @(posedge video_clk) begin
    if (rst) begin
      state      <= S_WAIT;
      h_cnt      <= '0;
      v_cnt      <= '0;
      dly        <= '0;
      frame_in_d <= 1'b1;
      hs_q       <= ~HS_POL;
      vs_q       <= ~VS_POL;
      de_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      underflow  <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_in_d <= frame_in;

      if (state == S_DELAY && state_nxt == S_DELAY) begin
        dly <= dly + DLY_W'(1);
      end else begin
        dly <= '0;
      end

      if (stay_run) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        end else begin
          h_cnt <= h_cnt + CNT_W'(1);
        end
      end else begin
        h_cnt <= '0;
        v_cnt <= '0;
      end

      de_q <= stay_run && de_i;
      hs_q <= (stay_run && hs_i) ? HS_POL : ~HS_POL;
      vs_q <= (stay_run && vs_i) ? VS_POL : ~VS_POL;
      x_q  <= (stay_run && de_i) ? h_cnt : '0;
      y_q  <= (stay_run && de_i) ? v_cnt : '0;

      if (state_nxt == S_DELAY) begin
        underflow <= 1'b0;
      end else if (rd_en_i && vid.fifo_empty) begin
        underflow <= 1'b1;
      end
    end
  end

  assign pix_d         = vid.fifo_q;
  assign vid.rd_en     = rd_en_i;
  assign vid.hs        = hs_q;
  assign vid.vs        = vs_q;
  assign vid.de        = de_q;
  assign vid.x         = x_q;
  assign vid.y         = y_q;
  assign vid.vout_data = de_q ? pix_d : '0;

endmodule

// File: doc/video_timing_lock.md
Name: video_timing_lock

Overview:
- Parametrised successor to the fixed camera-to-LCD timing block.
- Generates hs/vs/de timing with programmable porches and sync polarities, plus the read strobe for an external one-cycle-latency pixel FIFO.
- Phase-locks the raster to a camera frame-start edge after a programmable delay; supports free-run, one-shot lock and continuous resync modes.
- Flags FIFO underflow. Sits between the camera FIFO read port and the LCD/HDMI encoder, all on video_clk.

Parameters:
- DATA_WIDTH, 16, pixel width
- H_ACTIVE, 480, active pixels per line
- H_FP, 2, horizontal front porch (clocks)
- H_SYNC, 41, hs pulse width
- H_BP, 2, horizontal back porch
- V_ACTIVE, 272, active lines
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 10, vs pulse width
- V_BP, 2, vertical back porch
- HS_POL, 0, 1 = hs active-high, 0 = active-low
- VS_POL, 0, same rule for vs
- CNT_W, 12, width of counters and of x/y
- DLY_W, 20, width of lock_delay

Ports:
- video_clk  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- frame_in  in  1  camera frame-start level, already in the video_clk domain
- lock_en  in  1  1 = lock raster to frame_in; 0 = free-run
- resync_en  in  1  1 = every frame_in rising edge during RUN re-locks the raster
- lock_delay  in  DLY_W  clocks from detected edge to raster start
- fifo_empty  in  1  external FIFO empty flag
- fifo_q  in  DATA_WIDTH  external FIFO read data, valid one cycle after rd_en
- rd_en  out  1  FIFO read strobe
- hs  out  1  horizontal sync, registered
- vs  out  1  vertical sync, registered
- de  out  1  data enable, registered
- vout_data  out  DATA_WIDTH  pixel data aligned with de
- x  out  CNT_W  column of the current de pixel
- y  out  CNT_W  row of the current de pixel
- frame_done  out  1  one-cycle pulse on the last clock of a frame
- locked  out  1  high in RUN while lock_en = 1
- underflow  out  1  sticky FIFO-underflow flag

Behaviour:
- H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP; V_TOTAL is formed the same way. Both must fit in CNT_W bits.
- Line order: active, front porch, sync, back porch. h_cnt runs 0..H_TOTAL-1; v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1.
- Internal signals:
  - de_i = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hs_i asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs_i asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
- rd_en = de_i && state == RUN, combinational.
- hs, vs, de, x, y are registered one cycle after the counters, so de lines up with fifo_q.
- vout_data = de ? fifo_q : 0.
- Edge detect: frame_in_d is a register whose reset value is 1, so a frame_in held high through reset gives no edge. edge = frame_in & ~frame_in_d.
- FSM:
  - WAIT: counters held at 0; de = 0; hs/vs inactive. If lock_en = 0, go to RUN next cycle. Else on edge, go to DELAY with dly = 0.
  - DELAY: counters held at 0. When dly == lock_delay, go to RUN; otherwise dly increments. lock_delay = 0 gives exactly one DELAY cycle.
  - RUN: counters advance every clock. If edge && lock_en && resync_en, go to DELAY with dly = 0 and the counters cleared, abandoning the current frame. Otherwise edges are ignored.
  - lock_en falling during RUN: keep free-running.
  - lock_en rising during RUN: takes effect only through resync.
- Edge latency: edge at cycle T gives DELAY at T+1, RUN at T+2+lock_delay with h = v = 0. rd_en is high that same cycle; de is high one cycle later.
- frame_done pulses in the cycle where h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1. If a resync edge arrives in that same cycle, frame_done still pulses and the FSM goes to DELAY.
- underflow is set when rd_en && fifo_empty. It is cleared by rst or by entry to DELAY.
- Reset values:
  - state WAIT
  - hs = ~HS_POL, vs = ~VS_POL
  - de = 0, rd_en = 0, x = 0, y = 0
  - frame_done = 0, locked = 0, underflow = 0
- Reset asserted mid-frame: all outputs reach their reset values on the next edge. No partial line is emitted after reset.

Test Plan:
- Sim params: H = 4/1/2/1 (H_TOTAL 8), V = 3/1/1/1 (V_TOTAL 6), HS_POL = VS_POL = 1.
- Free-run (lock_en = 0) after rst release:
  - RUN one cycle after release.
  - de high 4 of every 8 clocks on rows 0–2.
  - hs high at h = 5..6, registered one cycle late.
  - vs high on row 4.
  - frame_done every 48 clocks.
- Lock, lock_delay = 3, frame_in rising at cycle T:
  - rd_en first high at T+5; de first high at T+6 with x = 0, y = 0.
  - locked high from T+5.
- frame_in held high through rst, lock_en = 1: no lock until frame_in falls and rises again; outputs idle meanwhile.
- resync_en = 1, edge mid-line at h = 2, v = 1:
  - Next cycle de = 0 and the counters are cleared.
  - With lock_delay = 0, the raster restarts at row 0 two cycles after the edge.
  - With resync_en = 0, the same edge changes nothing.
- fifo_empty = 1 during one rd_en cycle: underflow rises next cycle and stays high. It clears on the next lock edge (DELAY entry) or on rst.
- rst pulse during an active line: the next cycle shows de = 0, hs = vs = 0, x = y = 0, state WAIT.
